deser_align_ctrl: RTL and testbench
===================================

DESER_ALIGN_CTRL -- requirements
Module: deser_align_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, which sets the deserialized word width.
REQ-002 The block SHALL have parameter TRAIN_PAT, default 8'h5C, which is the expected training word.
REQ-003 The block SHALL have parameter SETTLE_CYC, default 4, which sets the wait in clk cycles after each bitslip.
REQ-004 The block SHALL have parameter LOCK_CNT, default 16, which is the number of consecutive matches required to lock.
REQ-005 The block SHALL have parameter LOSS_CNT, default 4, which is the number of consecutive mismatches that drops lock.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: request to begin alignment, sampled as a level.
REQ-009 The block SHALL have port data_in, input, DATA_W bits: parallel word from the deserializer.
REQ-010 The block SHALL have port data_vld, input, 1 bit: data_in qualifier.
REQ-011 The block SHALL have port bitslip, output, 1 bit: one-cycle slip pulse to the deserializer.
REQ-012 The block SHALL have port locked, output, 1 bit: word alignment achieved.
REQ-013 The block SHALL have port align_err, output, 1 bit: sticky flag meaning no alignment was found after DATA_W slips.
REQ-014 The block SHALL have port busy, output, 1 bit: high in every state except IDLE, LOCKED and FAIL.

Function
REQ-015 The block SHALL implement the FSM states IDLE, CHECK, SLIP, SETTLE, VERIFY, LOCKED and FAIL.
REQ-016 In IDLE, start=1 SHALL move the FSM to CHECK on the next cycle, with slip_count=0.
REQ-017 In CHECK, on data_vld: data_in==TRAIN_PAT SHALL go to VERIFY with match_count=1; a mismatch SHALL go to SLIP if slip_count<DATA_W-1, else to FAIL.
REQ-018 In SLIP, bitslip SHALL be 1 for exactly one cycle, slip_count SHALL increment, and the FSM SHALL go to SETTLE.
REQ-019 In SETTLE, the FSM SHALL wait exactly SETTLE_CYC cycles with data ignored, then go to CHECK.
REQ-020 In VERIFY, on data_vld: a match SHALL increment match_count; reaching LOCK_CNT SHALL go to LOCKED; a mismatch SHALL clear match_count and apply the REQ-017 mismatch rule.
REQ-021 In LOCKED, locked SHALL be 1; consecutive mismatches SHALL count up, any match SHALL clear the count, and reaching LOSS_CNT SHALL go to CHECK with slip_count=0; locked SHALL fall in the same cycle that CHECK is entered.
REQ-022 In FAIL, align_err SHALL be 1; start=1 SHALL clear align_err and go to CHECK with slip_count=0.
REQ-023 When data_vld=0, no counter SHALL change and no state transition SHALL occur, except the SETTLE countdown and the SLIP exit.
REQ-024 locked SHALL rise on the cycle after the LOCK_CNT-th consecutive matching valid word is sampled.
REQ-025 start SHALL be ignored outside IDLE and FAIL.
REQ-026 Counters SHALL be sized as clog2(max+1) and SHALL saturate, never wrap.
REQ-027 bitslip SHALL never be high on two consecutive cycles.

Reset
REQ-028 On reset=0 at a clk edge, the block SHALL enter IDLE; bitslip, locked, align_err and busy SHALL be 0; all counters SHALL be 0.
REQ-029 Reset mid-slip or mid-settle SHALL abort immediately, with no further bitslip pulse after the reset edge.

Configuration
REQ-030 With DESER_ALIGN_STATS_EN defined, the block SHALL add output slip_cnt (4 bits, slips used for the current lock, held while LOCKED) and output relock_cnt (8 bits, LOCKED-to-CHECK transitions, saturating at 255, cleared only by reset).
REQ-031 Without DESER_ALIGN_STATS_EN, neither port nor any of their logic SHALL exist.

Verification
REQ-032 Aligned stream: reset released, start=1, data_in=8'h5C on every valid cycle -> no bitslip; locked=1 on the cycle after the 16th word.
REQ-033 Stream rotated by 3 bits, with the model rotating back on each bitslip -> exactly 3 bitslip pulses, each followed by at least 4 quiet cycles; then locked; slip_cnt=3 (with the macro).
REQ-034 Garbage data 8'h00 -> exactly 7 bitslip pulses, then FAIL with align_err=1 and busy=0; start=1 -> align_err clears and the sequence restarts.
REQ-035 In LOCKED, 3 mismatches, 1 match, then 3 mismatches -> stays locked; 4 consecutive mismatches -> locked=0 and CHECK entered, relock_cnt=1.
REQ-036 reset=0 during SETTLE after the 2nd slip -> IDLE next cycle, all outputs 0, no bitslip afterwards.
REQ-037 data_vld toggling 1:1 on an aligned stream -> lock after 16 valid words (32 cycles); counters frozen on invalid cycles.

Source files
------------

// File: rtl/deser_align_ctrl.sv
// deser_align_ctrl: word-alignment controller for a serial deserializer.
// Watches the parallel word for a known training pattern, issues bitslip
// pulses until it is found, confirms it over LOCK_CNT consecutive valid
// words, and drops lock after LOSS_CNT consecutive bad words.
// Optional feature macro: DESER_ALIGN_STATS_EN adds the slip_cnt and
// relock_cnt statistics outputs.
module deser_align_ctrl #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] TRAIN_PAT  = 8'h5C,
  parameter int                SETTLE_CYC = 4,
  parameter int                LOCK_CNT   = 16,
  parameter int                LOSS_CNT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  output logic              bitslip,
  output logic              locked,
  output logic              align_err,
  output logic              busy
`ifdef DESER_ALIGN_STATS_EN
  ,
  output logic [3:0]        slip_cnt,
  output logic [7:0]        relock_cnt
`endif
);

  // Counter widths: each holds 0..max, so clog2(max+1) bits.
  localparam int SW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(SETTLE_CYC + 1);

  localparam logic [SW-1:0] SLIP_LAST   = SW'(DATA_W - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CNT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);

  localparam logic [SW-1:0] S_ONE = SW'(1);
  localparam logic [MW-1:0] M_ONE = MW'(1);
  localparam logic [LW-1:0] L_ONE = LW'(1);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    VERIFY = 3'd4,
    LOCKED = 3'd5,
    FAIL   = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0] slip_count;
  logic [MW-1:0] match_count;
  logic [LW-1:0] loss_count;
  logic [TW-1:0] settle_count;

  // Only valid words can match or mismatch; invalid cycles are neutral.
  logic hit, miss;
  assign hit  = data_vld && (data_in == TRAIN_PAT);
  assign miss = data_vld && (data_in != TRAIN_PAT);

  // Out of slip budget: a miss now means no alignment exists.
  logic slips_left;
  assign slips_left = (slip_count < SLIP_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = CHECK;
      CHECK: begin
        if (hit)       state_nxt = (LOCK_CNT <= 1) ? LOCKED : VERIFY;
        else if (miss) state_nxt = slips_left ? SLIP : FAIL;
      end
      SLIP:   state_nxt = SETTLE;
      SETTLE: if (settle_count >= SETTLE_LAST) state_nxt = CHECK;
      VERIFY: begin
        if (hit && match_count >= MATCH_LAST) state_nxt = LOCKED;
        else if (miss)                        state_nxt = slips_left ? SLIP : FAIL;
      end
      LOCKED: if (miss && loss_count >= LOSS_LAST) state_nxt = CHECK;
      FAIL:   if (start) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure state decodes, so reset forces them low immediately
  // and bitslip can never outlive the single SLIP cycle.
  always_comb begin
    bitslip   = (state == SLIP);
    locked    = (state == LOCKED);
    align_err = (state == FAIL);
    busy      = !((state == IDLE) || (state == LOCKED) || (state == FAIL));
  end

  // Alignment counters; all saturate and only move on valid words,
  // except the settle timer and the slip increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slip_count   <= '0;
      match_count  <= '0;
      loss_count   <= '0;
      settle_count <= '0;
    end else begin
      unique case (state)
        IDLE, FAIL: begin
          if (start) begin
            slip_count  <= '0;
            match_count <= '0;
            loss_count  <= '0;
          end
        end
        CHECK: begin
          if (hit)       match_count <= M_ONE;
          else if (miss) match_count <= '0;
        end
        SLIP: begin
          if (slip_count != SLIP_LAST) slip_count <= slip_count + S_ONE;
          settle_count <= '0;
        end
        SETTLE: begin
          if (settle_count < SETTLE_LAST) settle_count <= settle_count + T_ONE;
        end
        VERIFY: begin
          if (hit) begin
            if (match_count != MATCH_MAX) match_count <= match_count + M_ONE;
          end else if (miss) begin
            match_count <= '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            loss_count <= '0;
          end else if (miss) begin
            if (loss_count >= LOSS_LAST) begin
              // Lock lost: restart the search from scratch.
              loss_count  <= '0;
              slip_count  <= '0;
              match_count <= '0;
            end else begin
              loss_count <= loss_count + L_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DESER_ALIGN_STATS_EN
  logic [3:0] slip_stat;
  logic [7:0] relock_stat;

  // Snapshot the slips used on entry to LOCKED; relocks count lock losses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slip_stat   <= '0;
      relock_stat <= '0;
    end else begin
      if (state_nxt == LOCKED && state != LOCKED) slip_stat <= 4'(slip_count);
      if (state == LOCKED && state_nxt == CHECK && relock_stat != 8'hFF)
        relock_stat <= relock_stat + 8'd1;
    end
  end

  assign slip_cnt   = slip_stat;
  assign relock_cnt = relock_stat;
`endif

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Directed testbench for deser_align_ctrl (default parameters).
// Build with DESER_ALIGN_STATS_EN defined to also check the stats ports.
module tb_deser_align_ctrl;

  localparam logic [7:0] PAT = 8'h5C;

  logic       clk = 1'b0;
  logic       reset, start, data_vld;
  logic [7:0] data_in;
  logic       bitslip, locked, align_err, busy;
`ifdef DESER_ALIGN_STATS_EN
  logic [3:0] slip_cnt;
  logic [7:0] relock_cnt;
`endif

  deser_align_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_vld(data_vld), .bitslip(bitslip), .locked(locked),
    .align_err(align_err), .busy(busy)
`ifdef DESER_ALIGN_STATS_EN
    , .slip_cnt(slip_cnt), .relock_cnt(relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Deserializer model state: data_in = PAT rotated left by rot.
  int rot, cyc, nslip, consec_slip, last_slip, min_gap;
  bit prev_slip, use_model;

  function automatic logic [7:0] rot_word(input int k);
    logic [15:0] t;
    t = {PAT, PAT} << k;
    return t[15:8];
  endfunction

  // One clock: sample outputs 1 ns after the edge, update the model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bitslip) begin
      if (prev_slip) consec_slip++;
      if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      last_slip = cyc;
      nslip++;
      rot = (rot + 7) % 8;
    end
    prev_slip = bitslip;
    if (use_model) data_in = rot_word(rot);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; data_vld = 1'b0; data_in = 8'h00; use_model = 1'b0;
    tick(); tick();
    reset = 1'b1;
    nslip = 0; consec_slip = 0; last_slip = -1; min_gap = 1000; prev_slip = 1'b0; rot = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bitslip !== 1'b0) $display("FAIL reset_bitslip: got %b want 0", bitslip); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passes++;
    checks++; if (align_err !== 1'b0) $display("FAIL reset_align_err: got %b want 0", align_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
`ifdef DESER_ALIGN_STATS_EN
    checks++; if ({slip_cnt, relock_cnt} !== 12'h000) $display("FAIL reset_stats: got %0h/%0h want 0/0", slip_cnt, relock_cnt); else passes++;
`endif
  endtask

  // Aligned stream; start held high the whole time must not disturb anything.
  task automatic test_aligned();
    do_reset();
    data_in = PAT; data_vld = 1'b1; start = 1'b1;
    tick();  // IDLE -> CHECK
    checks++; if (busy !== 1'b1) $display("FAIL aligned_busy: got %b want 1", busy); else passes++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++; if (locked !== 1'b0) $display("FAIL aligned_early: locked %b want 0 after 15 words", locked); else passes++;
      end
    end
    checks++; if (locked !== 1'b1) $display("FAIL aligned_lock: locked %b want 1 after 16 words", locked); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL aligned_busy_lk: got %b want 0", busy); else passes++;
    tick(); tick();
    checks++; if (locked !== 1'b1) $display("FAIL aligned_hold: locked %b want 1 with start high", locked); else passes++;
    checks++; if (nslip !== 0) $display("FAIL aligned_slips: got %0d want 0", nslip); else passes++;
    start = 1'b0;
  endtask

  task automatic test_slip();
    int n;
    do_reset();
    use_model = 1'b1; rot = 3; data_in = rot_word(3); data_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (locked !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (locked !== 1'b1) $display("FAIL slip_lock: locked %b want 1 after %0d cycles", locked, n); else passes++;
    checks++; if (nslip !== 3) $display("FAIL slip_count: got %0d want 3", nslip); else passes++;
    checks++; if (min_gap < 5) $display("FAIL slip_gap: min pulse spacing %0d want >=5", min_gap); else passes++;
    checks++; if (consec_slip !== 0) $display("FAIL slip_consec: got %0d want 0", consec_slip); else passes++;
`ifdef DESER_ALIGN_STATS_EN
    checks++; if (slip_cnt !== 4'd3) $display("FAIL slip_stat: got %0d want 3", slip_cnt); else passes++;
`endif
  endtask

  task automatic test_fail();
    int n;
    do_reset();
    data_in = 8'h00; data_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (align_err !== 1'b1 && n < 300) begin tick(); n++; end
    checks++; if (align_err !== 1'b1) $display("FAIL fail_err: got %b want 1 after %0d cycles", align_err, n); else passes++;
    checks++; if (nslip !== 7) $display("FAIL fail_slips: got %0d want 7", nslip); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL fail_busy: got %b want 0", busy); else passes++;
    checks++; if (consec_slip !== 0) $display("FAIL fail_consec: got %0d want 0", consec_slip); else passes++;
    tick(); tick();
    checks++; if (align_err !== 1'b1) $display("FAIL fail_sticky: got %b want 1", align_err); else passes++;
    start = 1'b1;
    tick();  // FAIL -> CHECK
    start = 1'b0;
    checks++; if ({align_err, busy} !== 2'b01) $display("FAIL fail_restart: err/busy %b%b want 01", align_err, busy); else passes++;
    tick();  // CHECK sees 00 -> SLIP
    checks++; if (bitslip !== 1'b1) $display("FAIL fail_reslip: bitslip %b want 1", bitslip); else passes++;
  endtask

  // Lock on an aligned stream; no comparisons of its own.
  task automatic lock_clean();
    do_reset();
    data_in = PAT; data_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
  endtask

  task automatic test_loss();
    lock_clean();
    checks++; if (locked !== 1'b1) $display("FAIL loss_pre: locked %b want 1", locked); else passes++;
    data_in = 8'h00; for (int i = 0; i < 3; i++) tick();
    data_in = PAT;   tick();
    data_in = 8'h00; for (int i = 0; i < 3; i++) tick();
    checks++; if (locked !== 1'b1) $display("FAIL loss_hold: locked %b want 1", locked); else passes++;
    // Idle cycles between mismatches must not reset or advance the count.
    data_vld = 1'b0; tick(); tick();
    checks++; if (locked !== 1'b1) $display("FAIL loss_invalid: locked %b want 1", locked); else passes++;
    data_vld = 1'b1; tick();  // 4th consecutive mismatch
    checks++; if ({locked, busy} !== 2'b01) $display("FAIL loss_drop: locked/busy %b%b want 01", locked, busy); else passes++;
`ifdef DESER_ALIGN_STATS_EN
    checks++; if (relock_cnt !== 8'd1) $display("FAIL loss_relock: got %0d want 1", relock_cnt); else passes++;
`endif
    tick();  // CHECK with slip_count 0 -> SLIP
    checks++; if (bitslip !== 1'b1) $display("FAIL loss_reslip: bitslip %b want 1", bitslip); else passes++;
  endtask

  task automatic test_reset_settle();
    int n;
    do_reset();
    data_in = 8'h00; data_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (nslip < 2 && n < 100) begin tick(); n++; end
    checks++; if (nslip !== 2) $display("FAIL rst_settle_reach: slips %0d want 2", nslip); else passes++;
    tick();  // now in SETTLE
    reset = 1'b0;
    tick();
    checks++; if ({bitslip, locked, align_err, busy} !== 4'b0000) $display("FAIL rst_settle_out: got %b want 0000", {bitslip, locked, align_err, busy}); else passes++;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (nslip !== 2) $display("FAIL rst_settle_noslip: slips %0d want 2", nslip); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_settle_idle: busy %b want 0", busy); else passes++;
  endtask

  // data_vld toggles; garbage is presented on invalid cycles and must be ignored.
  task automatic test_vld_toggle();
    do_reset();
    data_in = PAT; data_vld = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      data_vld = i[0];
      data_in  = i[0] ? PAT : 8'h00;
      tick();
      if (i == 29) begin
        checks++; if (locked !== 1'b0) $display("FAIL toggle_early: locked %b want 0 after 15 words", locked); else passes++;
      end
    end
    checks++; if (locked !== 1'b1) $display("FAIL toggle_lock: locked %b want 1 after 16 words", locked); else passes++;
    checks++; if (nslip !== 0) $display("FAIL toggle_slips: got %0d want 0", nslip); else passes++;
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_aligned();
    test_slip();
    test_fail();
    test_loss();
    test_reset_settle();
    test_vld_toggle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
